serial_cmp_ctrl: RTL
====================

# serial_cmp_ctrl

Sequencer for the right-to-left (LSB-first) bit-serial comparison cell. It latches two WIDTH-bit operands and presents one bit pair per clock to an external comparison cell. The cell's carry output is registered and fed back as the next carry input, so one cell time-shares the whole comparison. The final carry is reported as the result with a start/busy/done handshake. The block sits between the operand source and the single combinational cell instance, which stays outside this block.

## Interface
- WIDTH, 8, operand width in bits; legal range 2..64.
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  request; sampled only in IDLE.
- op_a  input  WIDTH  operand A; sampled with start.
- op_b  input  WIDTH  operand B; sampled with start.
- le_mode  input  1  sampled with start; 0 = compute A<B, 1 = compute A<=B.
- cell_n  output  1  carry-in to the cell (registered carry).
- cell_a  output  1  current A bit to the cell (A shift register bit 0).
- cell_b  output  1  current B bit to the cell (B shift register bit 0).
- cell_N  input  1  carry-out from the cell; cell computes N = n&(~A|B) | ~A&B.
- busy  output  1  high while a comparison is in progress.
- done  output  1  one-cycle pulse when result becomes valid.
- result  output  1  comparison result; held until the next accepted start.

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- Reset values: busy=0, done=0, result=0. Shift registers, carry register and counter are all 0, so cell_n=cell_a=cell_b=0.
- IDLE, start=1:
  - load sh_a<=op_a, sh_b<=op_b, carry<=le_mode, cnt<=0.
  - go to RUN.
  - start=0 keeps the block in IDLE.
- RUN, each cycle:
  - carry<=cell_N.
  - sh_a and sh_b shift right by 1, filling with 0.
  - cnt<=cnt+1.
  - When cnt==WIDTH-1: result<=cell_N and go to DONE.
- DONE: done=1 for exactly this cycle, then go to IDLE unconditionally.
- Counter width is ceil(log2(WIDTH)) bits. It never wraps: the exit compare happens at WIDTH-1.
- Initial carry is the tie value, so equal operands yield le_mode.
- busy=1 in RUN and DONE; 0 in IDLE.
- start asserted in RUN or DONE is ignored and not queued. Operand inputs are don't-care outside the start cycle.
- cell_N is used only in RUN; its value in other states has no effect.
- result changes only at the RUN->DONE transition or on reset.
- rst_n low in any state, including mid-RUN, takes effect immediately: IDLE, all outputs at reset values, no done pulse for the aborted operation.

## Timing
- start sampled high at edge E0 (IDLE):
  - RUN occupies edges E1..E_WIDTH.
  - Bit i (LSB=0) is presented on cell_a/cell_b during the cycle before edge E(i+1).
- result is valid and done=1 in the cycle after E_WIDTH. done falls at E_(WIDTH+1).
- Latency from start to done is WIDTH+1 cycles. Throughput is one comparison per WIDTH+2 cycles.
- The earliest next start is accepted at edge E_(WIDTH+2), the first IDLE cycle.
- The cell path is purely combinational: cell_a/cell_b/cell_n come from registers, and cell_N must settle within one clock.

## Test plan
- WIDTH=8, A=0x05, B=0x09, le_mode=0 -> done pulses 9 cycles after start; result=1; busy high for 9 cycles.
- A=0x09, B=0x05, le_mode=0 -> result=0. Repeat with A=0xFF, B=0x00 -> result=0. A=0x00, B=0x80 (MSB-only difference) -> result=1.
- A=B=0x3C: le_mode=0 -> result=0; le_mode=1 -> result=1.
- Second start pulsed during RUN with different operands -> ignored; the first comparison's result is reported. A back-to-back start in the first IDLE cycle after done is accepted.
- rst_n pulsed low at the 4th RUN cycle -> busy=0, result=0 immediately. No done pulse follows. A new start after release completes normally.
- Against a behavioural model (result = le_mode ? A<=B : A<B): 1000 random operand pairs at WIDTH=8 and at WIDTH=2 -> all match; done is exactly one cycle each time.

Source files
------------

// File: rtl/serial_cmp_ctrl.sv
// Sequencer that time-shares one external bit-serial comparison cell, LSB first.
// The cell's carry-out is registered and fed back, and the final carry is the A<B / A<=B result.
module serial_cmp_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             le_mode,
  output logic             cell_n,
  output logic             cell_a,
  output logic             cell_b,
  input  logic             cell_N,
  output logic             busy,
  output logic             done,
  output logic             result
);

  localparam int CntW = $clog2(WIDTH);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] shA;
  logic [WIDTH-1:0] shB;
  logic             carry;
  logic [CntW-1:0]  cnt;

  // The initial carry is the tie value, so equal operands report le_mode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= StIdle;
      shA    <= '0;
      shB    <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      result <= 1'b0;
    end else begin
      case (state)
        StIdle: begin
          if (start) begin
            shA   <= op_a;
            shB   <= op_b;
            carry <= le_mode;
            cnt   <= '0;
            state <= StRun;
          end
        end
        StRun: begin
          carry <= cell_N;
          shA   <= shA >> 1;
          shB   <= shB >> 1;
          // The counter is cleared on the last bit instead of wrapping past WIDTH-1.
          if (cnt == LastCnt) begin
            cnt    <= '0;
            result <= cell_N;
            state  <= StDone;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        StDone: begin
          state <= StIdle;
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

  assign cell_n = carry;
  assign cell_a = shA[0];
  assign cell_b = shB[0];
  assign busy   = (state != StIdle);
  assign done   = (state == StDone);

endmodule
